dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

- Shares the single-port data memory (DMEM) between two requesters:
  - the core load/store port;
  - the debug/loader port, which preloads and inspects memory.
- Sits between the core's data-memory interface and the DMEM instance.
- Issues at most one memory command per cycle and routes synchronous read data back to the requester that issued the read.
- Supports a debug lock for atomic multi-cycle debug bursts.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- Clocking and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- core_req  input  1  core requests a memory access this cycle
- core_we  input  1  1 = write, 0 = read
- core_addr  input  AW  core byte address
- core_wdata  input  DW  core write data
- core_gnt  output  1  core command accepted this cycle (combinational)
- core_stall  output  1  core_req & ~core_gnt; freezes the core's PC
- core_rvalid  output  1  core read data valid (one cycle after the granted read)
- core_rdata  output  DW  read data for core
- dbg_req, dbg_we, dbg_addr, dbg_wdata  input  1/1/AW/DW  debug request, same meaning as the core signals
- dbg_lock  input  1  hold ownership for a debug burst
- dbg_gnt  output  1  debug command accepted this cycle
- dbg_rvalid  output  1  debug read data valid
- dbg_rdata  output  DW  read data for debug
- mem_en  output  1  memory command strobe
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data, valid the cycle after mem_en & ~mem_we

## Operation
State machine: ARB and DBG_LOCKED. Reset state is ARB.

In ARB:
- Only one requester active: it is granted.
- Both requesters active: the winner is decided by the priority rule (see Configuration).
- If debug is granted with dbg_lock=1, the next state is DBG_LOCKED.

In DBG_LOCKED:
- core_gnt=0 unconditionally.
- dbg_gnt = dbg_req.
- Return to ARB on the first cycle where dbg_lock=0 is sampled. That cycle is already arbitrated as ARB.

Grants and memory command:
- At most one of core_gnt and dbg_gnt is high in any cycle.
- mem_en = core_gnt | dbg_gnt.
- mem_we, mem_addr and mem_wdata are muxed from the winning requester.
- With no grant, mem_we=0 and the address/data outputs hold the core inputs (don't-care).

Read return:
- Registered rd_owner and rd_pend are set on a granted read (mem_we=0).
- On the next cycle, exactly one rvalid pulses; its rdata is mem_rdata passed through.
- Back-to-back reads from alternating owners are fully pipelined; each returns to its own requester.
- core_rdata/dbg_rdata are driven with mem_rdata at all times; only rvalid qualifies them.
- Writes produce no rvalid.

Requests:
- A requester must hold req, we, addr and wdata stable until it sees gnt.
- No transaction is dropped except by reset.

## Timing
- Grant: zero-cycle, combinational from the request and the registered state.
- Read data: exactly 1 cycle after grant.
- Reset values: state=ARB, rd_pend=0, rd_owner=CORE, last_gnt=DBG, core_rvalid=0, dbg_rvalid=0.
- During reset, core_gnt, dbg_gnt and mem_en are forced 0.
- Reset asserted mid-read: the pending rvalid is discarded and never issued after reset release.
- dbg_lock high while dbg_req is low in DBG_LOCKED: remain locked, mem_en=0, core stalls.
- Simultaneous requests on the cycle dbg_lock drops: arbitrated normally as ARB.

## Configuration
Macro DMEM_ARB_RR_EN:
- Defined: round-robin. On contention, the requester not recorded in last_gnt wins. last_gnt updates on every grant; first contention after reset goes to core.
- Undefined: fixed priority; core always wins contention. last_gnt is not implemented.
- The lock FSM is identical in both builds.

## Structure
- Package dmem_arb_pkg:
  - owner_e {OWN_CORE, OWN_DBG};
  - arb_state_e {ARB, DBG_LOCKED};
  - localparam for read latency (1).
- One sub-module, arb_pick: combinational two-way picker.
  - Inputs: requests, last_gnt, lock state.
  - Output: one-hot grant.
  - The `ifdef` for DMEM_ARB_RR_EN lives here.
- The top holds the FSM, the read-owner pipeline register and the muxes.

## Test plan
- Core-only read of 0x100 holding 0xDEADBEEF:
  - core_gnt=1 and mem_en=1 in cycle 0;
  - core_rvalid=1, core_rdata=0xDEADBEEF in cycle 1;
  - dbg_rvalid stays 0.
- Contention, core and debug reads both held high for 4 cycles:
  - RR build: grants C, D, C, D.
  - Fixed build: C, C, C, C, with dbg stalled until core_req drops.
  - Each rvalid returns to the correct owner one cycle after its grant.
- Debug burst with dbg_lock=1, writes to 0x0/0x4/0x8 while core_req=1:
  - core_stall=1 for those 3 cycles;
  - core is granted on the cycle after dbg_lock=0.
- Interleaved reads D@0x10 then C@0x20 in consecutive cycles:
  - dbg_rvalid is returned with M[0x10], then core_rvalid with M[0x20];
  - no cross-delivery.
- Reset asserted the cycle after a granted core read:
  - no core_rvalid appears after release;
  - first contention after release grants core.
- Write then read of 0x40 (0x12345678) by core:
  - no rvalid on the write;
  - the read returns 0x12345678.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the DMEM arbiter (used by both the fixed-priority and DMEM_ARB_RR_EN builds).
// Holds the owner/state encodings, the grant vector and the DMEM read latency.
package dmem_arb_pkg;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_e;

  typedef enum logic {
    ARB        = 1'b0,
    DBG_LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic core;
    logic dbg;
  } gnt_t;

  // Synchronous DMEM: read data is valid this many cycles after the command.
  localparam int RD_LATENCY = 1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of core, debug and DMEM-side signals around the arbiter (same in all builds, incl. DMEM_ARB_RR_EN).
// slave = arbiter view; master = requesters plus memory view.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_gnt;
  logic          core_stall;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_lock;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  mem_rdata,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output mem_rdata,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dmem_arbiter_arb_pick.sv
// Combinational two-way picker, one-hot grant, zero latency; DMEM_ARB_RR_EN selects round-robin
// on contention, otherwise core wins. While locked only debug can be granted; the loser simply waits.
module arb_pick
  import dmem_arb_pkg::*;
(
  input  logic   core_req_i,
  input  logic   dbg_req_i,
  input  owner_e last_gnt_i,
  input  logic   locked_i,
  output gnt_t   gnt_o
);

  logic core_wins;

`ifdef DMEM_ARB_RR_EN
  // Whoever was not served last goes first; reset value of last_gnt makes core win first.
  assign core_wins = (last_gnt_i == OWN_DBG);
`else
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt_i;
  assign core_wins       = 1'b1;
`endif

  always_comb begin
    gnt_o = '0;
    if (locked_i) begin
      gnt_o.dbg = dbg_req_i;
    end else if (core_req_i && dbg_req_i) begin
      gnt_o.core = core_wins;
      gnt_o.dbg  = ~core_wins;
    end else begin
      gnt_o.core = core_req_i;
      gnt_o.dbg  = dbg_req_i;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port DMEM between core and debug; DMEM_ARB_RR_EN enables round-robin contention.
// Grant is combinational, read data returns RD_LATENCY (1) cycle later; a loser stalls holding its request.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  arb_state_e state_q, state_d;
  owner_e     last_gnt;
  gnt_t       pick;
  gnt_t       gnt;
  logic       lock_hold;
  logic       read_issue;
  owner_e     issue_owner;

  logic   [RD_LATENCY-1:0] rd_pend_q, rd_pend_d;
  owner_e [RD_LATENCY-1:0] rd_owner_q, rd_owner_d;

  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;

  // A dropped dbg_lock releases the lock in the same cycle, so that cycle arbitrates normally.
  assign lock_hold = (state_q == DBG_LOCKED) && bus.dbg_lock;

  arb_pick u_pick (
    .core_req_i (bus.core_req),
    .dbg_req_i  (bus.dbg_req),
    .last_gnt_i (last_gnt),
    .locked_i   (lock_hold),
    .gnt_o      (pick)
  );

  always_comb begin
    gnt     = pick;
    state_d = ARB;
    if (!rst_n) begin
      gnt = '0;
    end
    if (lock_hold || (gnt.dbg && bus.dbg_lock)) begin
      state_d = DBG_LOCKED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  owner_e last_gnt_q, last_gnt_d;

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt.core) begin
      last_gnt_d = OWN_CORE;
    end else if (gnt.dbg) begin
      last_gnt_d = OWN_DBG;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= OWN_DBG;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

  assign last_gnt = last_gnt_q;
`else
  assign last_gnt = OWN_DBG;
`endif

  // Idle cycles present the core request on the memory pins; mem_en=0 makes it harmless.
  always_comb begin
    addr_mux  = bus.core_addr;
    wdata_mux = bus.core_wdata;
    if (gnt.dbg) begin
      addr_mux  = bus.dbg_addr;
      wdata_mux = bus.dbg_wdata;
    end
  end

  assign bus.core_gnt   = gnt.core;
  assign bus.dbg_gnt    = gnt.dbg;
  assign bus.core_stall = bus.core_req & ~gnt.core;
  assign bus.mem_en     = gnt.core | gnt.dbg;
  assign bus.mem_we     = (gnt.core & bus.core_we) | (gnt.dbg & bus.dbg_we);
  assign bus.mem_addr   = addr_mux;
  assign bus.mem_wdata  = wdata_mux;

  assign read_issue  = bus.mem_en & ~bus.mem_we;
  assign issue_owner = gnt.dbg ? OWN_DBG : OWN_CORE;

  always_comb begin
    rd_pend_d     = rd_pend_q;
    rd_owner_d    = rd_owner_q;
    rd_pend_d[0]  = read_issue;
    if (read_issue) begin
      rd_owner_d[0] = issue_owner;
    end
    for (int i = 1; i < RD_LATENCY; i++) begin
      rd_pend_d[i]  = rd_pend_q[i-1];
      rd_owner_d[i] = rd_owner_q[i-1];
    end
  end

  // Reset drops any read in flight; it is never returned afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        rd_owner_q[i] <= OWN_CORE;
      end
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign bus.core_rvalid = rd_pend_q[RD_LATENCY-1] && (rd_owner_q[RD_LATENCY-1] == OWN_CORE);
  assign bus.dbg_rvalid  = rd_pend_q[RD_LATENCY-1] && (rd_owner_q[RD_LATENCY-1] == OWN_DBG);
  assign bus.core_rdata  = bus.mem_rdata;
  assign bus.dbg_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a reference model and read scoreboard.
// Expected arbitration follows DMEM_ARB_RR_EN when it is defined for the build.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   hold     = 1'b0;

  // Reference model state: 0 = none, 1 = core, 2 = debug.
  bit   m_locked;
  int   m_last;
  logic [31:0] mem    [256];
  logic [31:0] shadow [256];

  typedef struct {
    int          due;
    int          owner;
    logic [31:0] data;
  } rd_exp_t;
  rd_exp_t rq[$];
  rd_exp_t mon_e;
  logic    mon_c, mon_d;
  logic [31:0] mon_data;

  logic obs_cgnt, obs_dgnt, obs_men, obs_cstall, obs_crv, obs_drv;
  logic [31:0] obs_crd, obs_drd;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Synchronous single-port DMEM.
  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end
  end

  task automatic check_b(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%b required=%b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Read-return monitor: pops whatever the model expected to come back this cycle.
  always @(negedge clk) begin
    mon_c    = 1'b0;
    mon_d    = 1'b0;
    mon_data = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      mon_e    = rq.pop_front();
      mon_c    = (mon_e.owner == 1);
      mon_d    = (mon_e.owner == 2);
      mon_data = mon_e.data;
    end
    check_b("core_rvalid", bus.core_rvalid, mon_c);
    check_b("dbg_rvalid", bus.dbg_rvalid, mon_d);
    if (mon_c) check_w("core_rdata", bus.core_rdata, mon_data);
    if (mon_d) check_w("dbg_rdata", bus.dbg_rdata, mon_data);
  end

  // One clock: predict the winner from the arbitration rules, check the command, advance the model.
  task automatic step();
    int          win;
    logic        we;
    logic [31:0] a, wd;
    @(negedge clk);
    obs_cgnt = bus.core_gnt;   obs_dgnt = bus.dbg_gnt;     obs_men = bus.mem_en;
    obs_cstall = bus.core_stall; obs_crv = bus.core_rvalid; obs_drv = bus.dbg_rvalid;
    obs_crd = bus.core_rdata;  obs_drd = bus.dbg_rdata;
    if (rst_n !== 1'b1)                 win = 0;
    else if (m_locked && bus.dbg_lock)  win = bus.dbg_req ? 2 : 0;
    else if (bus.core_req && bus.dbg_req) begin
`ifdef DMEM_ARB_RR_EN
      win = (m_last == 1) ? 2 : 1;
`else
      win = 1;
`endif
    end
    else if (bus.core_req)              win = 1;
    else if (bus.dbg_req)               win = 2;
    else                                win = 0;
    check_b("core_gnt", bus.core_gnt, win == 1);
    check_b("dbg_gnt", bus.dbg_gnt, win == 2);
    check_b("mem_en", bus.mem_en, win != 0);
    check_b("core_stall", bus.core_stall, bus.core_req && win != 1);
    if (win != 0) begin
      we = (win == 1) ? bus.core_we    : bus.dbg_we;
      a  = (win == 1) ? bus.core_addr  : bus.dbg_addr;
      wd = (win == 1) ? bus.core_wdata : bus.dbg_wdata;
      check_b("mem_we", bus.mem_we, we);
      check_w("mem_addr", bus.mem_addr, a);
      if (we) begin
        check_w("mem_wdata", bus.mem_wdata, wd);
        shadow[a[9:2]] = wd;
      end else begin
        rq.push_back('{due: cyc + 1, owner: win, data: shadow[a[9:2]]});
      end
      m_last = win;
    end else begin
      check_b("mem_we_idle", bus.mem_we, 1'b0);
    end
    m_locked = (rst_n === 1'b1) && bus.dbg_lock && (m_locked || win == 2);
    @(posedge clk);
    #1;
    if (!hold) begin
      if (win == 1) bus.core_req = 1'b0;
      if (win == 2) bus.dbg_req  = 1'b0;
    end
  endtask

  task automatic core_rq(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.core_req = 1'b1; bus.core_we = we; bus.core_addr = a; bus.core_wdata = d;
  endtask

  task automatic dbg_rq(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
  endtask

  task automatic do_reset(input int n);
    rst_n    = 1'b0;
    m_locked = 1'b0;
    m_last   = 2;
    rq.delete();
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((bus.core_req || bus.dbg_req) && n < budget) begin
      step();
      n++;
    end
    if (bus.core_req || bus.dbg_req) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: requests core=%b dbg=%b still pending after %0d cycles",
               bus.core_req, bus.dbg_req, budget);
      bus.core_req = 1'b0;
      bus.dbg_req  = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    rst_n = 1'b0;
    m_locked = 1'b0;
    m_last = 2;
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.dbg_req  = 1'b0; bus.dbg_we  = 1'b0; bus.dbg_addr  = '0; bus.dbg_wdata  = '0;
    bus.dbg_lock = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[32'h100 >> 2] = 32'hDEADBEEF;
    mem[32'h10 >> 2]  = 32'hA5A50010;
    mem[32'h20 >> 2]  = 32'h5A5A0020;
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];

    // Reset with both requesters asking: nothing may be granted.
    core_rq(1'b0, 32'h100, '0);
    dbg_rq(1'b0, 32'h10, '0);
    step();
    check_b("rst_core_gnt", obs_cgnt, 1'b0);
    check_b("rst_dbg_gnt", obs_dgnt, 1'b0);
    check_b("rst_mem_en", obs_men, 1'b0);
    check_b("rst_rvalid", obs_crv | obs_drv, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    check_b("post_reset_core_first", obs_cgnt, 1'b1);
    drain(10);
    step();

    // Core-only read of 0x100.
    core_rq(1'b0, 32'h100, '0);
    step();
    check_b("t1_core_gnt", obs_cgnt, 1'b1);
    check_b("t1_mem_en", obs_men, 1'b1);
    step();
    check_b("t1_core_rvalid", obs_crv, 1'b1);
    check_w("t1_core_rdata", obs_crd, 32'hDEADBEEF);
    check_b("t1_dbg_rvalid", obs_drv, 1'b0);

    // Leave debug as last served, then hold both reads for 4 cycles.
    dbg_rq(1'b0, 32'h30, '0);
    step();
    step();
    hold = 1'b1;
    core_rq(1'b0, 32'h20, '0);
    dbg_rq(1'b0, 32'h10, '0);
    for (int i = 0; i < 4; i++) begin
      step();
`ifdef DMEM_ARB_RR_EN
      check_b("t2_core_gnt_seq", obs_cgnt, (i % 2) == 0);
`else
      check_b("t2_core_gnt_seq", obs_cgnt, 1'b1);
`endif
    end
    hold = 1'b0;
    bus.core_req = 1'b0;
    step();
    check_b("t2_dbg_after_core_drop", obs_dgnt, 1'b1);
    step();

    // Locked debug burst while the core waits.
    bus.dbg_lock = 1'b1;
    dbg_rq(1'b1, 32'h0, $urandom);
    step();
    check_b("t3_first_dbg_gnt", obs_dgnt, 1'b1);
    core_rq(1'b0, 32'h30, '0);
    dbg_rq(1'b1, 32'h4, $urandom);
    step();
    check_b("t3_stall_a", obs_cstall, 1'b1);
    dbg_rq(1'b1, 32'h8, $urandom);
    step();
    check_b("t3_stall_b", obs_cstall, 1'b1);
    step();
    check_b("t3_stall_idle_locked", obs_cstall, 1'b1);
    check_b("t3_idle_mem_en", obs_men, 1'b0);
    bus.dbg_lock = 1'b0;
    step();
    check_b("t3_core_after_unlock", obs_cgnt, 1'b1);
    step();

    // Interleaved debug then core reads.
    dbg_rq(1'b0, 32'h10, '0);
    step();
    core_rq(1'b0, 32'h20, '0);
    step();
    check_b("t4_dbg_rvalid", obs_drv, 1'b1);
    check_w("t4_dbg_rdata", obs_drd, 32'hA5A50010);
    check_b("t4_core_rvalid_early", obs_crv, 1'b0);
    step();
    check_b("t4_core_rvalid", obs_crv, 1'b1);
    check_w("t4_core_rdata", obs_crd, 32'h5A5A0020);
    check_b("t4_dbg_rvalid_late", obs_drv, 1'b0);

    // Reset the cycle after a granted core read.
    core_rq(1'b0, 32'h100, '0);
    step();
    core_rq(1'b0, 32'h20, '0);
    dbg_rq(1'b0, 32'h10, '0);
    do_reset(2);
    step();
    check_b("t5_core_first", obs_cgnt, 1'b1);
    check_b("t5_no_stale_rvalid", obs_crv, 1'b0);
    drain(10);
    step();

    // Core write then read of 0x40.
    core_rq(1'b1, 32'h40, 32'h12345678);
    step();
    core_rq(1'b0, 32'h40, '0);
    step();
    check_b("t6_no_rvalid_on_write", obs_crv | obs_drv, 1'b0);
    step();
    check_b("t6_core_rvalid", obs_crv, 1'b1);
    check_w("t6_core_rdata", obs_crd, 32'h12345678);

    // Random traffic with lock toggling and occasional reset.
    for (int i = 0; i < 800; i++) begin
      if (!bus.core_req && $urandom_range(0, 2) != 0) begin
        a = $urandom_range(0, 255) << 2;
        core_rq(1'($urandom_range(0, 1)), a, $urandom);
      end
      if (!bus.dbg_req && $urandom_range(0, 2) != 0) begin
        a = $urandom_range(0, 255) << 2;
        dbg_rq(1'($urandom_range(0, 1)), a, $urandom);
      end
      if ($urandom_range(0, 5) == 0) bus.dbg_lock = ~bus.dbg_lock;
      if ($urandom_range(0, 199) == 0) do_reset(1);
      step();
    end
    bus.dbg_lock = 1'b0;
    drain(50);
    step();
    step();
    check_w("rd_queue_drained", 32'(rq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
